// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
// Sprite-DMA sequencer for the CPU-clock bus arbiter. It snoops CPU writes to
// DMA_REG_ADDR and then copies XFER_LEN bytes from page {wdata,8'h00} to
// OAM_DATA_ADDR. Each byte is a read followed by a write, and each access goes
// through the spr request/grant port. The sequencer stalls for as long as the
// arbiter withholds the grant.
//
// Ports:
//   i_clk, i_rst          CPU clock, synchronous active-high reset
//   i_bus_addr/wn/wdata   snooped arbitrated bus (wn=0 means write)
//   o_spr_req, i_spr_gnt  access request; it completes when req && gnt
//   o_spr_addr/wn/wdata   access address, direction (1=read), write data
//   i_spr_rdata           read data, valid in the granted read cycle
//   o_busy                transfer in progress (ALIGN through DONE)
//   o_done                one-cycle pulse at the end of a transfer
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic        r_parity;
  logic [7:0]  r_page, w_page_nxt;
  logic [8:0]  r_idx, w_idx_nxt;

  logic        r_spr_req, w_req_nxt;
  logic [15:0] r_spr_addr, w_addr_nxt;
  logic        r_spr_wn, w_wn_nxt;
  logic [7:0]  r_spr_wdata, w_wdata_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;

  logic        w_trigger;
  logic        w_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_parity    <= 1'b0;
      r_page      <= '0;
      r_idx       <= '0;
      r_spr_req   <= 1'b0;
      r_spr_addr  <= '0;
      r_spr_wn    <= 1'b1;
      r_spr_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_parity    <= ~r_parity;
      r_page      <= w_page_nxt;
      r_idx       <= w_idx_nxt;
      r_spr_req   <= w_req_nxt;
      r_spr_addr  <= w_addr_nxt;
      r_spr_wn    <= w_wn_nxt;
      r_spr_wdata <= w_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_wdata_nxt = r_spr_wdata;
    w_trigger   = (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;
    w_acc       = r_spr_req && i_spr_gnt;

    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_page_nxt  = i_bus_wdata;
          w_idx_nxt   = '0;
          // An odd-cycle trigger costs one extra alignment cycle.
          w_state_nxt = r_parity ? S_ALIGN : S_READ;
        end
      end
      S_ALIGN: w_state_nxt = S_READ;
      S_READ: begin
        if (w_acc) begin
          // The write-data register also serves as the byte buffer.
          w_wdata_nxt = i_spr_rdata;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_acc) begin
          w_idx_nxt   = r_idx + 9'd1;
          w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // The outputs are registered. They are derived from the next state so that
    // they line up with the state register. While an access is stalled, page
    // and idx do not change, so addr/wn/wdata stay constant.
    w_req_nxt  = 1'b0;
    w_addr_nxt = r_spr_addr;
    w_wn_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
    case (w_state_nxt)
      S_READ: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = {w_page_nxt, w_idx_nxt[7:0]};
      end
      S_WRITE: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = OAM_DATA_ADDR;
        w_wn_nxt   = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_spr_req   = r_spr_req;
  assign o_spr_addr  = r_spr_addr;
  assign o_spr_wn    = r_spr_wn;
  assign o_spr_wdata = r_spr_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl
// Directed bench for oam_dma_ctrl. The source memory is modelled as a fixed
// function of the address. Every granted access is logged and then compared
// with the expected read/write sequence.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .XFER_LEN     (256)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_bus_addr (bus_addr),
    .i_bus_wn   (bus_wn),
    .i_bus_wdata(bus_wdata),
    .o_spr_req  (spr_req),
    .i_spr_gnt  (spr_gnt),
    .o_spr_addr (spr_addr),
    .o_spr_wn   (spr_wn),
    .o_spr_wdata(spr_wdata),
    .i_spr_rdata(spr_rdata),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'h5C;
  endfunction

  assign spr_rdata = mem_f(spr_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter and a parity model (reset to 0, toggles every cycle).
  int cyc    = 0;
  bit tb_par = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tb_par <= rst ? 1'b0 : ~tb_par;
  end

  // Access log entry layout: {wn, addr, data}.
  logic [24:0] acc_q[$];
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (spr_req && spr_gnt)
      acc_q.push_back({spr_wn, spr_addr, spr_wn ? spr_rdata : spr_wdata});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic clear_log();
    acc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
  endtask

  // Trigger a transfer in a cycle of the requested parity. t is the trigger cycle.
  task automatic start_xfer(input logic [7:0] page, input bit odd, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (tb_par != odd && k < 4) begin
      @(negedge clk);
      k++;
    end
    clear_log();
    bus_addr  = 16'h4014;
    bus_wn    = 1'b0;
    bus_wdata = page;
    t         = cyc;
    @(negedge clk);
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
    if (odd) begin
      check("align_req", {31'b0, spr_req}, 32'd0);
      check("align_busy", {31'b0, busy}, 32'd1);
    end else begin
      check("first_req", {31'b0, spr_req}, 32'd1);
      check("first_addr", {16'b0, spr_addr}, {16'b0, page, 8'h00});
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 32'd1);
  endtask

  task automatic check_log(input string tag, input logic [7:0] page);
    int bad;
    logic [24:0] exp_r, exp_w;
    bad = 0;
    check({tag, "_len"}, acc_q.size(), 32'd512);
    for (int i = 0; i < 256; i++) begin
      exp_r = {1'b1, page, 8'(i), mem_f({page, 8'(i)})};
      exp_w = {1'b0, 16'h2004, mem_f({page, 8'(i)})};
      if (2 * i + 1 < acc_q.size()) begin
        if (acc_q[2*i] !== exp_r) bad++;
        if (acc_q[2*i+1] !== exp_w) bad++;
      end else begin
        bad++;
      end
    end
    check({tag, "_seq"}, bad, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k, bad;
    rst       = 1'b1;
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
    spr_gnt   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, spr_req}, 32'd0);
    check("rst_addr", {16'b0, spr_addr}, 32'h0);
    check("rst_wn", {31'b0, spr_wn}, 32'd1);
    check("rst_wdata", {24'b0, spr_wdata}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // A trigger in the same cycle as reset is lost.
    bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h02;
    @(negedge clk);
    rst = 1'b0; bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    @(negedge clk);
    check("rst_trig_busy", {31'b0, busy}, 32'd0);
    check("rst_trig_req", {31'b0, spr_req}, 32'd0);

    // Basic even start.
    start_xfer(8'h02, 1'b0, t);
    wait_done(700);
    check("even_done_cyc", done_cyc, t + 513);
    check("even_busy_cnt", busy_cnt, 32'd513);
    check_log("even", 8'h02);

    // Odd start.
    start_xfer(8'h02, 1'b1, t);
    wait_done(700);
    check("odd_done_cyc", done_cyc, t + 514);
    check("odd_busy_cnt", busy_cnt, 32'd514);
    check_log("odd", 8'h02);

    // Grant stall: 3 cycles on READ idx 5, 2 cycles on WRITE idx 5.
    start_xfer(8'h02, 1'b0, t);
    k = 0;
    while (!(spr_req && spr_wn && spr_addr == 16'h0205) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall_r_found", {16'b0, spr_addr}, 32'h0205);
    spr_gnt = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!(spr_req && spr_wn && spr_addr == 16'h0205)) bad++;
    end
    check("stall_r_hold", bad, 32'd0);
    spr_gnt = 1'b1;
    @(negedge clk);
    check("stall_w_addr", {16'b0, spr_addr}, 32'h2004);
    check("stall_w_data", {24'b0, spr_wdata}, {24'b0, mem_f(16'h0205)});
    spr_gnt = 1'b0;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (!(spr_req && !spr_wn && spr_addr == 16'h2004 && spr_wdata == mem_f(16'h0205))) bad++;
    end
    check("stall_w_hold", bad, 32'd0);
    spr_gnt = 1'b1;
    wait_done(700);
    check("stall_done_cyc", done_cyc, t + 518);
    check_log("stall", 8'h02);

    // Retrigger while busy is ignored.
    start_xfer(8'h02, 1'b0, t);
    k = 0;
    while (!(spr_req && spr_wn && spr_addr == 16'h0264) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("retrig_found", {16'b0, spr_addr}, 32'h0264);
    bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h07;
    @(negedge clk);
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    wait_done(700);
    check("retrig_done_cyc", done_cyc, t + 513);
    check("retrig_idle", {31'b0, busy}, 32'd0);
    check_log("retrig", 8'h02);

    // Reset during WRITE idx 40.
    start_xfer(8'h02, 1'b0, t);
    k = 0;
    while (!(spr_req && !spr_wn && acc_q.size() == 81) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("mrst_found", acc_q.size(), 32'd81);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_req", {31'b0, spr_req}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_addr", {16'b0, spr_addr}, 32'h0);
    check("mrst_done", {31'b0, done}, 32'd0);
    repeat (6) @(negedge clk);
    check("mrst_no_done", done_cnt, 32'd0);
    start_xfer(8'h03, 1'b0, t);
    wait_done(700);
    check("mrst_done_cyc", done_cyc, t + 513);
    check_log("restart", 8'h03);

    // Page $FF: the address must not carry into page $00.
    start_xfer(8'hFF, 1'b1, t);
    wait_done(700);
    check("ff_done_cyc", done_cyc, t + 514);
    check_log("ff", 8'hFF);
    check("ff_last_read", (acc_q.size() > 510) ? {16'b0, acc_q[510][23:8]} : 32'h0, 32'hFFFF);
    bad = 0;
    foreach (acc_q[i]) if (acc_q[i][23:8] == 16'h0000) bad++;
    check("ff_no_zero", bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
